f_npc_bp: RTL and testbench
===========================

# f_npc_bp

Fetch-stage PC register and next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces purely combinational next-PC selection with a predicted fetch stream. Branch/jump outcomes arrive from a later resolve (R) stage, which corrects mispredictions and trains the BTB. Exception entry (`req`) and `eret` keep absolute priority over all other redirects.

## Interface
- `ENTRIES`, 16: BTB entry count; power of two, 2..256.
- `IDX_W`, `$clog2(ENTRIES)`: index width; BTB index = `PC[IDX_W+1:2]`.
- `RESET_PC`, `32'h0000_3000`: `F_PC` value after reset.
- `EXC_VEC`, `32'h0000_4180`: exception handler entry.
- `CNT_W`, 16: misprediction counter width.

- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold `F_PC` (F/D stall).
- `req` input 1: exception/interrupt request.
- `eret` input 1: exception return.
- `EPC` input 32: return address from CP0.
- `R_valid` input 1: R stage holds a valid instruction.
- `R_is_ctrl` input 1: R instruction is a branch/jump/jr.
- `R_PC` input 32: PC of the R instruction.
- `R_taken` input 1: actual direction (1 for jumps).
- `R_actual_next` input 32: architecturally correct next PC of the R instruction.
- `R_pred_next` input 32: next PC predicted when it was fetched (carried down the pipe).
- `F_PC` output 32: current fetch address.
- `F_pred_next` output 32: predicted successor of `F_PC`, pipelined alongside the instruction.
- `F_pred_taken` output 1: prediction was a BTB-taken hit.
- `flush` output 1: younger instructions are wrong-path; kill them.
- `mis_count` output CNT_W: saturating misprediction count.

## Operation
- BTB entry: `valid`, `tag` = `PC[31:IDX_W+2]`, `target[31:0]`, `ctr[1:0]`.
- Lookup (combinational on `F_PC`): hit = valid && tag match. `F_pred_taken` = hit && `ctr[1]`. `F_pred_next` = `target` if `F_pred_taken`, else `F_PC + 4` (mod 2^32).
- `mispredict` = `R_valid && (R_pred_next != R_actual_next)`. Non-control instructions carry `PC+4` and never mispredict.
- Next-PC priority, highest first:
  1. `reset` -> `RESET_PC`
  2. `req` -> `EXC_VEC`
  3. `eret` -> `EPC`
  4. `mispredict` -> `R_actual_next`
  5. `stall` -> hold
  6. otherwise -> `F_pred_next`
- Redirects 2-4 override `stall`.
- `flush` = `req | eret | mispredict`, combinational, not gated by `reset`.
- Training when `R_valid && R_is_ctrl && !req`, at index/tag of `R_PC`:
  - taken, hit: `target <= R_actual_next`; `ctr` +1, saturating at 3.
  - taken, miss: allocate/overwrite; `valid=1`, `ctr=2'b10`.
  - not taken, hit: `ctr` -1, saturating at 0; target kept.
  - not taken, miss: no change.
- `mis_count` += 1 on each cycle with `mispredict && !req`; saturates at all-ones.

## Timing
- Reset (synchronous, wins over all inputs): `F_PC=RESET_PC`, all `valid=0`, all `ctr=2'b01`, `mis_count=0`.
  - After reset, `F_pred_next=RESET_PC+4`, `F_pred_taken=0`, `flush` follows inputs.
- `F_PC` register latency 1: the selected next PC appears the cycle after selection. Redirect penalty: 1 fetch cycle.
- BTB write and lookup in the same cycle at the same index: lookup sees pre-write contents; write visible next cycle.
- `req` and `mispredict` together: `EXC_VEC` taken; no training, no count.
- `eret` and `mispredict` together: `EPC` taken; training and count proceed.
- `stall` with no redirect: `F_PC`, `F_pred_*` stable; BTB training still occurs.
- `reset` asserted mid-operation: state fully reinitialised on that edge; pending R-stage inputs ignored.

## Test plan
- Reset -> `F_PC=0x3000`; `F_pred_next=0x3004`; `F_pred_taken=0`; `mis_count=0`. Four unstalled cycles -> `F_PC` 0x3004, 0x3008, 0x300C, 0x3010.
- Mispredict and training: R resolves taken branch `R_PC=0x3010`, `R_pred_next=0x3014`, `R_actual_next=0x3100`.
  - Same cycle: `flush=1`. Next cycle: `F_PC=0x3100`, `mis_count=1`.
  - Later fetch of 0x3010 -> `F_pred_taken=1`, `F_pred_next=0x3100`.
- Counter saturation (`ENTRIES=16`): trained entry at 0x3010, ctr=2, resolved not-taken twice -> ctr 1 then 0; `F_pred_next=0x3014`. Three taken resolves -> ctr saturates at 3; one not-taken -> still predicts taken.
- Aliasing: allocate 0x3010, then taken at 0x3050 (same index, different tag) -> lookup of 0x3010 misses, 0x3050 hits.
- Priority: `req`, `eret`, `mispredict`, `stall` all high -> `F_PC=0x4180`, BTB unchanged, `mis_count` unchanged.
  - Same with `req=0` -> `F_PC=EPC`.
- Saturation and mid-run reset: `CNT_W=2`, five mispredicts -> `mis_count=3`. Assert `reset` during a stall with a pending mispredict -> `F_PC=0x3000`, all lookups miss.

Source files
------------

// File: rtl/f_npc_bp.sv
// f_npc_bp - fetch PC register with BTB-based next-PC prediction.
//
// Keeps the fetch PC and predicts its successor from a direct-mapped branch
// target buffer. Each BTB entry holds a 2-bit saturating direction counter.
// Control-flow outcomes from the resolve (R) stage correct mispredictions
// and train the BTB. Exception entry and eret take priority over every other
// redirect.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   stall             : hold F_PC when no redirect is pending
//   req, eret, EPC    : exception entry, exception return and return address
//   R_*               : resolved instruction (valid, ctrl, PC, taken,
//                       correct next PC, next PC predicted at fetch time)
//   F_PC              : current fetch address
//   F_pred_next       : predicted successor of F_PC
//   F_pred_taken      : prediction came from a taken BTB hit
//   flush             : kill younger wrong-path instructions
//   mis_count         : saturating misprediction counter
module f_npc_bp #(
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = $clog2(ENTRIES),
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [31:0]      EPC,
    input  logic             R_valid,
    input  logic             R_is_ctrl,
    input  logic [31:0]      R_PC,
    input  logic             R_taken,
    input  logic [31:0]      R_actual_next,
    input  logic [31:0]      R_pred_next,
    output logic [31:0]      F_PC,
    output logic [31:0]      F_pred_next,
    output logic             F_pred_taken,
    output logic             flush,
    output logic [CNT_W-1:0] mis_count
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]            vld_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      tgt_q;
    logic [ENTRIES-1:0][1:0]       ctr_q;
    logic [31:0]                   pc_q, pc_d;
    logic [CNT_W-1:0]              mis_q;

    // The low two bits of R_PC do not take part in indexing or tagging.
    logic unused_rpc_lo;
    assign unused_rpc_lo = ^R_PC[1:0];

    // Lookup on the current fetch PC. It reads the pre-write array contents.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    assign f_idx        = pc_q[IDX_W+1:2];
    assign f_tag        = pc_q[31:IDX_W+2];
    assign f_hit        = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign F_pred_taken = f_hit && ctr_q[f_idx][1];
    assign F_pred_next  = F_pred_taken ? tgt_q[f_idx] : pc_q + 32'd4;

    // Non-control instructions carry PC+4 as both prediction and outcome,
    // so they never compare unequal.
    logic mispredict;
    assign mispredict = R_valid && (R_pred_next != R_actual_next);
    assign flush      = req | eret | mispredict;

    always_comb begin
        pc_d = F_pred_next;
        if (req)             pc_d = EXC_VEC;
        else if (eret)       pc_d = EPC;
        else if (mispredict) pc_d = R_actual_next;
        else if (stall)      pc_d = pc_q;
    end

    // Training port, addressed by the resolved instruction's PC.
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit, train;
    assign r_idx = R_PC[IDX_W+1:2];
    assign r_tag = R_PC[31:IDX_W+2];
    assign r_hit = vld_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign train = R_valid && R_is_ctrl && !req;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
            mis_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (train) begin
                if (R_taken) begin
                    tgt_q[r_idx] <= R_actual_next;
                    if (r_hit) begin
                        if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
                    end else begin
                        // Allocate or overwrite an aliasing entry as weakly taken.
                        vld_q[r_idx] <= 1'b1;
                        tag_q[r_idx] <= r_tag;
                        ctr_q[r_idx] <= 2'b10;
                    end
                end else if (r_hit && ctr_q[r_idx] != 2'b00) begin
                    ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
                end
            end
            if (mispredict && !req && mis_q != {CNT_W{1'b1}}) mis_q <= mis_q + 1'b1;
        end
    end

    assign F_PC      = pc_q;
    assign mis_count = mis_q;
endmodule

// File: tb/tb_f_npc_bp.sv
module tb_f_npc_bp;
    localparam int          ENT = 16;
    localparam logic [31:0] RST = 32'h0000_3000;
    localparam logic [31:0] EXC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, stall, req, eret, R_valid, R_is_ctrl, R_taken;
    logic [31:0] EPC, R_PC, R_actual_next, R_pred_next;
    logic [31:0] F_PC, F_pred_next, F_PC2, F_pred_next2;
    logic        F_pred_taken, flush, F_pred_taken2, flush2;
    logic [15:0] mis_count;
    logic [1:0]  mis_count2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    f_npc_bp #(.ENTRIES(ENT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .EPC(EPC),
        .R_valid(R_valid), .R_is_ctrl(R_is_ctrl), .R_PC(R_PC), .R_taken(R_taken),
        .R_actual_next(R_actual_next), .R_pred_next(R_pred_next),
        .F_PC(F_PC), .F_pred_next(F_pred_next), .F_pred_taken(F_pred_taken),
        .flush(flush), .mis_count(mis_count));

    // Narrow-counter instance sharing the same stimulus.
    f_npc_bp #(.ENTRIES(ENT), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .EPC(EPC),
        .R_valid(R_valid), .R_is_ctrl(R_is_ctrl), .R_PC(R_PC), .R_taken(R_taken),
        .R_actual_next(R_actual_next), .R_pred_next(R_pred_next),
        .F_PC(F_PC2), .F_pred_next(F_pred_next2), .F_pred_taken(F_pred_taken2),
        .flush(flush2), .mis_count(mis_count2));

    // Reference model: a table of entries keyed by word address modulo ENT,
    // with the tag being the word address divided by ENT.
    bit          m_known = 0;
    logic [31:0] m_pc;
    bit          m_vld [ENT];
    int unsigned m_tag [ENT];
    logic [31:0] m_tgt [ENT];
    int          m_ctr [ENT];
    int          m_mis;

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction
    function automatic int unsigned tagof(logic [31:0] pc);
        return (pc / 4) / ENT;
    endfunction
    function automatic bit m_hit(logic [31:0] pc);
        return m_vld[slot(pc)] && m_tag[slot(pc)] == tagof(pc);
    endfunction
    function automatic bit m_ptaken(logic [31:0] pc);
        return m_hit(pc) && m_ctr[slot(pc)] >= 2;
    endfunction
    function automatic logic [31:0] m_pnext(logic [31:0] pc);
        return m_ptaken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          mp;
        logic [31:0] npc;
        int          s;
        if (reset) begin
            m_pc = RST;
            for (int i = 0; i < ENT; i++) begin m_vld[i] = 0; m_ctr[i] = 1; end
            m_mis = 0;
            m_known = 1;
            return;
        end
        mp = R_valid && (R_pred_next != R_actual_next);
        if (req)       npc = EXC;
        else if (eret) npc = EPC;
        else if (mp)   npc = R_actual_next;
        else if (stall) npc = m_pc;
        else           npc = m_pnext(m_pc);
        if (R_valid && R_is_ctrl && !req) begin
            s = slot(R_PC);
            if (R_taken) begin
                if (m_hit(R_PC)) begin
                    m_tgt[s] = R_actual_next;
                    if (m_ctr[s] < 3) m_ctr[s]++;
                end else begin
                    m_vld[s] = 1; m_tag[s] = tagof(R_PC); m_tgt[s] = R_actual_next; m_ctr[s] = 2;
                end
            end else if (m_hit(R_PC) && m_ctr[s] > 0) m_ctr[s]--;
        end
        if (mp && !req) m_mis++;
        m_pc = npc;
    endtask

    task automatic check_model();
        bit mp;
        mp = R_valid && (R_pred_next != R_actual_next);
        chk("flush", {31'b0, flush}, {31'b0, req | eret | mp});
        if (!m_known) return;
        chk("F_PC", F_PC, m_pc);
        chk("F_pred_next", F_pred_next, m_pnext(m_pc));
        chk("F_pred_taken", {31'b0, F_pred_taken}, {31'b0, m_ptaken(m_pc)});
        chk("mis_count", {16'b0, mis_count}, (m_mis > 65535) ? 32'hFFFF : m_mis);
        chk("mis_count2", {30'b0, mis_count2}, (m_mis > 3) ? 32'd3 : m_mis);
        chk("F_PC2", F_PC2, m_pc);
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, clock.
    task automatic cyc(bit rs, bit st, bit rq, bit er, logic [31:0] epc,
                       bit rv, bit rc, logic [31:0] rpc, bit rt,
                       logic [31:0] ract, logic [31:0] rpred);
        reset = rs; stall = st; req = rq; eret = er; EPC = epc;
        R_valid = rv; R_is_ctrl = rc; R_PC = rpc; R_taken = rt;
        R_actual_next = ract; R_pred_next = rpred;
        #3;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic go(logic [31:0] pc); cyc(0, 0, 0, 1, pc, 0, 0, 0, 0, 0, 0); endtask
    // Resolve a branch whose prediction was right (no redirect).
    task automatic res(logic [31:0] pc, bit tk, logic [31:0] nxt);
        cyc(0, 1, 0, 0, 0, 1, 1, pc, tk, nxt, nxt);
    endtask

    initial begin
        logic [31:0] rpc, act;
        bit          tk;
        reset = 0; stall = 0; req = 0; eret = 0; EPC = 0; R_valid = 0;
        R_is_ctrl = 0; R_PC = 0; R_taken = 0; R_actual_next = 0; R_pred_next = 0;
        @(posedge clk); #1;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", F_PC, 32'h3000);
        chk("rst_pnext", F_pred_next, 32'h3004);
        chk("rst_ptaken", {31'b0, F_pred_taken}, 32'd0);
        chk("rst_mis", {16'b0, mis_count}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("seq_pc", F_PC, 32'h3000 + 32'(4 * i));
        end

        // Mispredicted taken branch at 0x3010.
        R_valid = 1; R_PC = 32'h3010; R_pred_next = 32'h3014; R_actual_next = 32'h3100; #1;
        chk("mp_flush", {31'b0, flush}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h3010, 1, 32'h3100, 32'h3014);
        chk("mp_pc", F_PC, 32'h3100);
        chk("mp_cnt", {16'b0, mis_count}, 32'd1);
        go(32'h3010);
        chk("trained_tk", {31'b0, F_pred_taken}, 32'd1);
        chk("trained_tgt", F_pred_next, 32'h3100);

        // Counter walk: 2 -> 1 -> 0, then up to 3, then back to 2.
        res(32'h3010, 0, 32'h3014);
        res(32'h3010, 0, 32'h3014);
        go(32'h3010);
        chk("ctr0_pnext", F_pred_next, 32'h3014);
        for (int i = 0; i < 3; i++) res(32'h3010, 1, 32'h3100);
        res(32'h3010, 0, 32'h3014);
        go(32'h3010);
        chk("ctr_sat_tk", {31'b0, F_pred_taken}, 32'd1);

        // Aliasing at index 4.
        res(32'h3050, 1, 32'h3500);
        go(32'h3010);
        chk("alias_miss", {31'b0, F_pred_taken}, 32'd0);
        go(32'h3050);
        chk("alias_hit", F_pred_next, 32'h3500);

        // Priority: everything asserted.
        cyc(0, 1, 1, 1, 32'h3400, 1, 1, 32'h3200, 1, 32'h3300, 32'h3204);
        chk("pri_req_pc", F_PC, EXC);
        chk("pri_req_cnt", {16'b0, mis_count}, 32'd1);
        go(32'h3200);
        chk("pri_no_train", {31'b0, F_pred_taken}, 32'd0);
        cyc(0, 1, 0, 1, 32'h3400, 1, 1, 32'h3200, 1, 32'h3300, 32'h3204);
        chk("pri_eret_pc", F_PC, 32'h3400);
        chk("pri_eret_cnt", {16'b0, mis_count}, 32'd2);

        // Narrow counter saturation.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 0, 32'h3600, 0, 32'h3604, 32'h3608);
        chk("sat2", {30'b0, mis_count2}, 32'd3);
        chk("cnt16", {16'b0, mis_count}, 32'd7);

        // Reset during a stall with a pending mispredict.
        cyc(1, 1, 0, 0, 0, 1, 1, 32'h3050, 1, 32'h3700, 32'h3054);
        chk("mid_rst_pc", F_PC, RST);
        chk("mid_rst_cnt", {16'b0, mis_count}, 32'd0);
        go(32'h3050);
        chk("mid_rst_miss", {31'b0, F_pred_taken}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rpc = 32'h3000 + 32'(4 * $urandom_range(0, 63));
            tk  = 1'($urandom);
            act = tk ? 32'h3000 + 32'(4 * $urandom_range(0, 127)) : rpc + 32'd4;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                32'h3000 + 32'(4 * $urandom_range(0, 63)),
                1'($urandom), 1'($urandom), rpc, tk, act,
                ($urandom_range(0, 2) == 0) ? rpc + 32'd4 : act);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
